// File: rtl/spi_pkt_tx.sv
// spi_pkt_tx: frames one packet (4-byte header + PACKAGE_SIZE payload bytes
// pulled from the packet FIFO) and shifts it out as an SPI mode-0 master.
//
// Handshake: fifo_rd_en is a one-cycle request. Every cycle in WAIT with
// fifo_valid high carries the requested byte. Cycles where fifo_valid is
// high outside WAIT are ignored. While the block waits, SCLK is held low,
// so any FIFO latency only stretches the low phase in front of a byte.
module spi_pkt_tx #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          PACKAGE_SIZE = 10,
    parameter int          CNT_WIDTH    = 16,
    parameter int          CLK_DIV      = 2,
    parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_ready,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_valid,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  spi_cs_n,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    output logic                  busy,
    output logic                  pkt_done,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic                  overrun,
    output logic                  underrun
);

    // The shifter is 8 bits wide; DATA_WIDTH is expected to be 8.
    localparam int                   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] PKG_SIZE = CNT_WIDTH'(PACKAGE_SIZE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        SHIFT = 3'd4,
        GUARD = 3'd5
    } state_t;

    state_t               state_q;
    logic [DIV_W-1:0]     div_q;
    logic [2:0]           bit_q;
    logic [1:0]           hdr_idx_q;
    logic [CNT_WIDTH-1:0] pay_cnt_q;
    logic [7:0]           shreg_q;
    logic [15:0]          hdr_cnt_q;
    logic                 fifo_rd_en_q;
    logic                 spi_cs_n_q;
    logic                 spi_sclk_q;
    logic                 spi_mosi_q;
    logic                 pkt_done_q;
    logic [CNT_WIDTH-1:0] pkt_cnt_q;
    logic                 overrun_q;
    logic                 underrun_q;

    logic                 tick;
    logic [7:0]           hdr_next_d;
    logic [CNT_WIDTH-1:0] pay_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_d;

    // Phase tick, the header byte that follows the current one, and counter increments.
    always_comb begin
        tick       = (div_q == DIV_LAST);
        pay_cnt_d  = pay_cnt_q + CNT_WIDTH'(1);
        pkt_cnt_d  = pkt_cnt_q + CNT_WIDTH'(1);
        hdr_next_d = hdr_cnt_q[7:0];
        case (hdr_idx_q)
            2'd0:    hdr_next_d = SYNC_WORD[7:0];
            2'd1:    hdr_next_d = hdr_cnt_q[15:8];
            default: hdr_next_d = hdr_cnt_q[7:0];
        endcase
    end

    // Packet framing FSM with SPI bit timing; all outputs registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            hdr_idx_q    <= '0;
            pay_cnt_q    <= '0;
            shreg_q      <= '0;
            hdr_cnt_q    <= '0;
            fifo_rd_en_q <= 1'b0;
            spi_cs_n_q   <= 1'b1;
            spi_sclk_q   <= 1'b0;
            spi_mosi_q   <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_cnt_q    <= '0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            fifo_rd_en_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            if (pkt_ready && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pkt_ready) begin
                        state_q    <= HDR;
                        spi_cs_n_q <= 1'b0;
                        spi_sclk_q <= 1'b0;
                        shreg_q    <= SYNC_WORD[15:8];
                        spi_mosi_q <= SYNC_WORD[15];
                        div_q      <= '0;
                        bit_q      <= '0;
                        hdr_idx_q  <= '0;
                        pay_cnt_q  <= '0;
                        hdr_cnt_q  <= 16'(pkt_cnt_q);
                    end
                end

                HDR, SHIFT: begin
                    if (!tick) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!spi_sclk_q) begin
                            spi_sclk_q <= 1'b1;
                        end else begin
                            // End of a bit: SCLK falls and MOSI moves to the next bit.
                            spi_sclk_q <= 1'b0;
                            if (bit_q != 3'd7) begin
                                bit_q      <= bit_q + 3'd1;
                                shreg_q    <= {shreg_q[6:0], 1'b0};
                                spi_mosi_q <= shreg_q[6];
                            end else begin
                                bit_q <= '0;
                                if (state_q == HDR) begin
                                    if (hdr_idx_q == 2'd3) begin
                                        state_q <= FETCH;
                                    end else begin
                                        hdr_idx_q  <= hdr_idx_q + 2'd1;
                                        shreg_q    <= hdr_next_d;
                                        spi_mosi_q <= hdr_next_d[7];
                                    end
                                end else begin
                                    pay_cnt_q <= pay_cnt_d;
                                    if (pay_cnt_d < PKG_SIZE) begin
                                        state_q <= FETCH;
                                    end else begin
                                        state_q <= GUARD;
                                    end
                                end
                            end
                        end
                    end
                end

                FETCH: begin
                    if (fifo_empty) begin
                        underrun_q <= 1'b1;
                        spi_cs_n_q <= 1'b1;
                        spi_sclk_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        fifo_rd_en_q <= 1'b1;
                        state_q      <= WAIT;
                    end
                end

                WAIT: begin
                    if (fifo_valid) begin
                        shreg_q    <= fifo_dout[7:0];
                        spi_mosi_q <= fifo_dout[7];
                        spi_sclk_q <= 1'b0;
                        div_q      <= '0;
                        bit_q      <= '0;
                        state_q    <= SHIFT;
                    end
                end

                GUARD: begin
                    if (tick) begin
                        spi_cs_n_q <= 1'b1;
                        pkt_done_q <= 1'b1;
                        pkt_cnt_q  <= pkt_cnt_d;
                        div_q      <= '0;
                        state_q    <= IDLE;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = fifo_rd_en_q;
    assign spi_cs_n   = spi_cs_n_q;
    assign spi_sclk   = spi_sclk_q;
    assign spi_mosi   = spi_mosi_q;
    assign busy       = (state_q != IDLE);
    assign pkt_done   = pkt_done_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;

endmodule
